// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Definitions shared by the ALU arbiter slice.
//   WORD_LEN / FUNCT_LEN : operand and function-code widths
//   FUNCT_*              : function codes understood by the ALU
//   state_t              : arbiter FSM state encoding
//   onehot2()            : requester id -> 2-bit one-hot strobe
package alu_arbiter_pkg;

    localparam int WORD_LEN  = 16;
    localparam int FUNCT_LEN = 3;

    localparam logic [FUNCT_LEN-1:0] FUNCT_ADD   = 3'd0;
    localparam logic [FUNCT_LEN-1:0] FUNCT_NAND  = 3'd1;
    localparam logic [FUNCT_LEN-1:0] FUNCT_PASSA = 3'd2;
    localparam logic [FUNCT_LEN-1:0] FUNCT_SUB   = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu
// Purely combinational ALU shared by the arbiter's requesters.
// Ports:
//   a, b    in  WORD_LEN   operands
//   funct   in  FUNCT_LEN  function code (ADD, NAND, PASSA, SUB)
//   result  out WORD_LEN   result, modulo 2^WORD_LEN; unknown codes give 0
//   zero    out 1          result == 0
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [WORD_LEN-1:0]  a,
    input  logic [WORD_LEN-1:0]  b,
    input  logic [FUNCT_LEN-1:0] funct,
    output logic [WORD_LEN-1:0]  result,
    output logic                 zero
);

    // Sums and differences are WORD_LEN wide, so carry/borrow simply drop off.
    always_comb begin
        result = '0;
        case (funct)
            FUNCT_ADD:   result = a + b;
            FUNCT_NAND:  result = ~(a & b);
            FUNCT_PASSA: result = a;
            FUNCT_SUB:   result = a - b;
            default:     result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one ALU between two requesters. A request is granted in IDLE,
// evaluated in EXEC and the registered result is presented in RESP until the
// owning requester consumes it.
//
// Build option: define ALU_ARB_RR_EN for round-robin arbitration on
// contention (a last-grant register is kept). Without it requester 0 always
// wins contention and no last-grant register exists.
//
// Ports:
//   clk           in  1          rising-edge clock
//   rst_n         in  1          asynchronous active-low reset
//   req_valid     in  2          per-requester request (bit 0 = requester 0)
//   req_ready     out 2          accept strobe, one-hot or zero, same cycle
//   req0_a/_b     in  WORD_LEN   requester 0 operands
//   req0_funct    in  FUNCT_LEN  requester 0 function code
//   req1_a/_b     in  WORD_LEN   requester 1 operands
//   req1_funct    in  FUNCT_LEN  requester 1 function code
//   rsp_valid     out 2          result valid for the owner, one-hot or zero
//   rsp_ready     in  2          per-requester result consume
//   rsp_out       out WORD_LEN   registered ALU result
//   rsp_zero      out 1          registered rsp_out == 0
//   busy          out 1          FSM not in IDLE
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a request; grant is combinational
// ST_EXEC | ALU works on latched operands, result captured at exit
// ST_RESP | rsp_valid to owner until owner's rsp_ready
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [WORD_LEN-1:0]  req0_a,
    input  logic [WORD_LEN-1:0]  req0_b,
    input  logic [FUNCT_LEN-1:0] req0_funct,
    input  logic [WORD_LEN-1:0]  req1_a,
    input  logic [WORD_LEN-1:0]  req1_b,
    input  logic [FUNCT_LEN-1:0] req1_funct,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WORD_LEN-1:0]  rsp_out,
    output logic                 rsp_zero,
    output logic                 busy
);

    state_t               state;
    logic                 owner;
    logic [WORD_LEN-1:0]  op_a;
    logic [WORD_LEN-1:0]  op_b;
    logic [FUNCT_LEN-1:0] op_funct;
    logic                 grant_id;
    logic [WORD_LEN-1:0]  alu_result;
    logic                 alu_zero;

`ifdef ALU_ARB_RR_EN
    logic                 last_grant;
`endif

    // Winner selection. A lone requester always wins; only the both-valid
    // case depends on the arbitration policy.
    always_comb begin
        grant_id = 1'b0;
        if (req_valid == 2'b10) begin
            grant_id = 1'b1;
        end
`ifdef ALU_ARB_RR_EN
        else if (req_valid == 2'b11) begin
            grant_id = ~last_grant;
        end
`endif
    end

    // The accept strobe is gated by rst_n so no grant is shown while the FSM
    // is held in reset and cannot record it.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (state == ST_IDLE) && (req_valid != 2'b00)) begin
            req_ready = onehot2(grant_id);
        end
    end

    assign busy = (state != ST_IDLE);

    alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .funct  (op_funct),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_funct  <= '0;
            rsp_valid <= 2'b00;
            rsp_out   <= '0;
            rsp_zero  <= 1'b1;
`ifdef ALU_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid != 2'b00) begin
                        owner    <= grant_id;
                        op_a     <= grant_id ? req1_a     : req0_a;
                        op_b     <= grant_id ? req1_b     : req0_b;
                        op_funct <= grant_id ? req1_funct : req0_funct;
`ifdef ALU_ARB_RR_EN
                        last_grant <= grant_id;
`endif
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_out   <= alu_result;
                    rsp_zero  <= alu_zero;
                    rsp_valid <= onehot2(owner);
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the owner's consume strobe matters here.
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_funct = '0, req1_funct = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [15:0] rsp_out;
    logic        rsp_zero;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_funct(req0_funct),
        .req1_a(req1_a), .req1_b(req1_b), .req1_funct(req1_funct),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [15:0] ref_alu(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (f)
            FUNCT_ADD:   r = ia + ib;
            FUNCT_NAND:  r = ~(ia & ib);
            FUNCT_PASSA: r = ia;
            FUNCT_SUB:   r = ia - ib;
            default:     r = 0;
        endcase
        return r[15:0];
    endfunction

    int          m_phase = 0;      // 0 waiting, 1 computing, 2 presenting
    logic        m_owner = 1'b0;
    logic        m_last  = 1'b1;
    logic [15:0] m_a = '0, m_b = '0;
    logic [2:0]  m_f = '0;
    logic [15:0] m_out = '0;
    logic        m_zero = 1'b1;

    function automatic logic pick(input logic [1:0] v);
        if (v == 2'b10) return 1'b1;
`ifdef ALU_ARB_RR_EN
        if (v == 2'b11) return !m_last;
`endif
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_out   <= '0;
            m_zero  <= 1'b1;
            m_last  <= 1'b1;
            m_owner <= 1'b0;
        end else if (m_phase == 0) begin
            if (req_valid != 2'b00) begin
                m_owner <= pick(req_valid);
                m_last  <= pick(req_valid);
                m_a     <= pick(req_valid) ? req1_a : req0_a;
                m_b     <= pick(req_valid) ? req1_b : req0_b;
                m_f     <= pick(req_valid) ? req1_funct : req0_funct;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_out   <= ref_alu(m_f, m_a, m_b);
            m_zero  <= (ref_alu(m_f, m_a, m_b) == 16'h0000);
            m_phase <= 2;
        end else begin
            if (rsp_ready[m_owner]) m_phase <= 0;
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        chk("req_ready",
            32'((rst_n && m_phase == 0 && req_valid != 2'b00) ? (pick(req_valid) ? 2'b10 : 2'b01) : 2'b00),
            32'(req_ready)) ;
        chk("rsp_valid", 32'(rsp_valid), 32'((m_phase == 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("rsp_out", 32'(rsp_out), 32'(m_out));
        chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
    end

    // ---------------- stimulus ----------------
    // Called and returns at posedge+1.
    task automatic run_op(input logic [1:0] v,
                          input logic [15:0] a0, input logic [15:0] b0, input logic [2:0] f0,
                          input logic [15:0] a1, input logic [15:0] b1, input logic [2:0] f1,
                          input int hold, input bit poke, input bit keep,
                          output logic gid, output logic [15:0] res, output logic z,
                          output int waited);
        req_valid = v;
        req0_a = a0; req0_b = b0; req0_funct = f0;
        req1_a = a1; req1_b = b1; req1_funct = f1;
        waited = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_seen", 32'(req_ready != 2'b00), 32'd1);
        gid = req_ready[1];
        @(posedge clk); #1;
        if (!keep) begin
            req_valid = 2'b00;
            req0_a = 16'($urandom); req0_b = 16'($urandom); req0_funct = 3'($urandom);
            req1_a = 16'($urandom); req1_b = 16'($urandom); req1_funct = 3'($urandom);
        end
        @(negedge clk);
        chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rsp_latency", 32'(rsp_valid), gid ? 32'd2 : 32'd1);
        res = rsp_out;
        z   = rsp_zero;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (poke) begin
                req_valid = 2'b11;
                rsp_ready = gid ? 2'b01 : 2'b10;
            end
            @(negedge clk);
            if (poke) begin
                chk("hold_busy", 32'(busy), 32'd1);
                chk("hold_ready", 32'(req_ready), 32'd0);
                chk("hold_valid", 32'(rsp_valid), gid ? 32'd2 : 32'd1);
                chk("hold_out", 32'(rsp_out), 32'(res));
            end
        end
        @(posedge clk); #1;
        rsp_ready = gid ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        if (poke) req_valid = keep ? v : 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        g;
        logic [15:0] r;
        logic        z;
        int          w;
        logic        exp_order [4];

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_zero", 32'(rsp_zero), 32'd1);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Requester 0 ADD, accepted on first edge after reset
        run_op(2'b01, 16'h7FFF, 16'h0001, FUNCT_ADD, 16'h0, 16'h0, 3'd0, 0, 0, 0, g, r, z, w);
        chk("add0_wait", 32'(w), 32'd0);
        chk("add0_gid", 32'(g), 32'd0);
        chk("add0_out", 32'(r), 32'h8000);
        chk("add0_zero", 32'(z), 32'd0);

        // Requester 1 sequence
        run_op(2'b10, 16'h0, 16'h0, 3'd0, 16'hFFFF, 16'h0001, FUNCT_ADD, 1, 0, 0, g, r, z, w);
        chk("add1_gid", 32'(g), 32'd1);
        chk("add1_out", 32'(r), 32'h0000);
        chk("add1_zero", 32'(z), 32'd1);
        run_op(2'b10, 16'h0, 16'h0, 3'd0, 16'h0005, 16'h0007, FUNCT_SUB, 0, 0, 0, g, r, z, w);
        chk("sub1_out", 32'(r), 32'hFFFE);
        chk("sub1_zero", 32'(z), 32'd0);
        run_op(2'b10, 16'h0, 16'h0, 3'd0, 16'hFFFF, 16'hFFFF, FUNCT_NAND, 0, 0, 0, g, r, z, w);
        chk("nand1_out", 32'(r), 32'h0000);
        chk("nand1_zero", 32'(z), 32'd1);

        // Undefined function; non-owner rsp_ready poked while waiting
        run_op(2'b01, 16'h1234, 16'h0001, 3'd7, 16'h0, 16'h0, 3'd0, 3, 1, 0, g, r, z, w);
        chk("undef_out", 32'(r), 32'h0000);
        chk("undef_zero", 32'(z), 32'd1);

        // Long hold in RESP
        run_op(2'b01, 16'h0001, 16'h0001, FUNCT_ADD, 16'h0, 16'h0, 3'd0, 5, 1, 0, g, r, z, w);
        chk("hold_res", 32'(r), 32'h0002);

        // Reset pulse during EXEC drops the operation
        req_valid = 2'b01;
        req0_a = 16'h0003; req0_b = 16'h0004; req0_funct = FUNCT_ADD;
        @(negedge clk);
        chk("rstx_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #2;
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("rstx_busy", 32'(busy), 32'd0);
        chk("rstx_valid", 32'(rsp_valid), 32'd0);
        chk("rstx_out", 32'(rsp_out), 32'd0);
        chk("rstx_zero", 32'(rsp_zero), 32'd1);
        chk("rstx_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstx_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Contention, both requesters valid throughout
`ifdef ALU_ARB_RR_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int k = 0; k < 4; k++) begin
            run_op(2'b11, 16'h0010, 16'h0001, FUNCT_SUB, 16'h0020, 16'h0000, FUNCT_PASSA,
                   0, 0, 1, g, r, z, w);
            chk("contend_gid", 32'(g), 32'(exp_order[k]));
            chk("contend_res", 32'(r), g ? 32'h0020 : 32'h000F);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;

        // Randomized traffic against the model
        for (int k = 0; k < 40; k++) begin
            run_op(2'($urandom_range(1, 3)),
                   16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                   16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0,
                   g, r, z, w);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
